// File: rtl/traffic_pkg.sv
// Shared state codes, lamp encodings and lamp decode helpers for the traffic phase sequencer.
package traffic_pkg;

   localparam int CNT_W_DEF = 8;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALLRED1   = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALLRED2   = 3'd5,
      FLASH     = 3'd6
   } phase_e;

   function automatic logic [2:0] ns_lamp(input phase_e s, input logic on);
      case (s)
         NS_GREEN:  return LAMP_GRN;
         NS_YELLOW: return LAMP_YEL;
         FLASH:     return on ? LAMP_YEL : LAMP_OFF;
         default:   return LAMP_RED;
      endcase
   endfunction

   function automatic logic [2:0] ew_lamp(input phase_e s, input logic on);
      case (s)
         EW_GREEN:  return LAMP_GRN;
         EW_YELLOW: return LAMP_YEL;
         FLASH:     return on ? LAMP_RED : LAMP_OFF;
         default:   return LAMP_RED;
      endcase
   endfunction

endpackage

// File: rtl/traffic_phase_sequencer_phase_timer.sv
// Loadable seconds down-counter; stops at 1 and flags expiry on the tick that finds it at 1.
module phase_timer #(
   parameter int CNT_W   = 8,
   parameter int RST_VAL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] sec_left,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (tick_en && (cnt_q > CNT_W'(1)))
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= CNT_W'(RST_VAL);
      else     cnt_q <= cnt_d;
   end

   assign sec_left = cnt_q;
   assign expire   = tick_en && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Actuated NS/EW traffic phase controller with pedestrian handshake.
// Define NIGHT_FLASH_EN to enable the night flashing mode entered from ALLRED2.
module traffic_phase_sequencer
   import traffic_pkg::*;
#(
   parameter int GREEN_NS_S = 20,
   parameter int GREEN_EW_S = 15,
   parameter int YELLOW_S   = 3,
   parameter int ALLRED_S   = 1,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_en,
   input  logic             car_ew,
   input  logic             ped_req,
   input  logic             night,
   output logic             ped_ack,
   output logic             walk,
   output logic [2:0]       ns_light,
   output logic [2:0]       ew_light,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] sec_left
);

   phase_e           state_q, state_d;
   logic             pend_q, pend_d;
   logic             flash_on_q, flash_on_d;
   logic [2:0]       ns_q, ew_q;
   logic             walk_q;
   logic             load, expire;
   logic [CNT_W-1:0] load_val;

   phase_timer #(.CNT_W(CNT_W), .RST_VAL(ALLRED_S)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .tick_en  (tick_en),
      .load     (load),
      .load_val (load_val),
      .sec_left (sec_left),
      .expire   (expire)
   );

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      load_val = '0;
      case (state_q)
         ALLRED2: if (expire) begin
            load = 1'b1;
`ifdef NIGHT_FLASH_EN
            if (night) begin
               state_d  = FLASH;
               load_val = '0;
            end else
`endif
            begin
               state_d  = NS_GREEN;
               load_val = CNT_W'(GREEN_NS_S);
            end
         end
         // Rest in NS green, re-checking demand every second.
         NS_GREEN: if (expire) begin
            load = 1'b1;
            if (car_ew || pend_q) begin
               state_d  = NS_YELLOW;
               load_val = CNT_W'(YELLOW_S);
            end else begin
               load_val = CNT_W'(1);
            end
         end
         NS_YELLOW: if (expire) begin
            state_d = ALLRED1; load = 1'b1; load_val = CNT_W'(ALLRED_S);
         end
         ALLRED1: if (expire) begin
            state_d = EW_GREEN; load = 1'b1; load_val = CNT_W'(GREEN_EW_S);
         end
         EW_GREEN: if (expire) begin
            state_d = EW_YELLOW; load = 1'b1; load_val = CNT_W'(YELLOW_S);
         end
         EW_YELLOW: if (expire) begin
            state_d = ALLRED2; load = 1'b1; load_val = CNT_W'(ALLRED_S);
         end
         FLASH: if (tick_en && !night) begin
            state_d = ALLRED2; load = 1'b1; load_val = CNT_W'(ALLRED_S);
         end
         default: begin
            state_d = ALLRED2; load = 1'b1; load_val = CNT_W'(ALLRED_S);
         end
      endcase
   end

   // Entering EW green serves the request, so the clear beats a same-cycle ped_req.
   always_comb begin
      pend_d = pend_q;
      if (state_d == EW_GREEN && state_q != EW_GREEN)
         pend_d = 1'b0;
      else if (ped_req && state_q != EW_GREEN)
         pend_d = 1'b1;
   end

   always_comb begin
      flash_on_d = 1'b0;
      if (state_d == FLASH)
         flash_on_d = (state_q != FLASH) ? 1'b1 : (flash_on_q ^ tick_en);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ALLRED2;
         pend_q     <= 1'b0;
         flash_on_q <= 1'b0;
         ns_q       <= LAMP_RED;
         ew_q       <= LAMP_RED;
         walk_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         flash_on_q <= flash_on_d;
         ns_q       <= ns_lamp(state_d, flash_on_d);
         ew_q       <= ew_lamp(state_d, flash_on_d);
         walk_q     <= (state_d == EW_GREEN);
      end
   end

   assign phase    = state_q;
   assign ns_light = ns_q;
   assign ew_light = ew_q;
   assign walk     = walk_q;
   assign ped_ack  = pend_q;

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Actuated two-road (NS main, EW side) traffic-light phase controller.
- Timing is driven by the one-second `tick_en` strobe from the clock divider. All timing is in seconds, counted only on `tick_en`.
- Sequences green, yellow and all-red phases.
- Rests in NS green until EW traffic or a pedestrian request is pending.
- Sits between the divider and the lamp drivers / 7-segment countdown display.

Parameters:
- GREEN_NS_S, 20, minimum NS green seconds (≥1)
- GREEN_EW_S, 15, EW green seconds (≥1)
- YELLOW_S, 3, yellow seconds, both roads (≥1)
- ALLRED_S, 1, all-red clearance seconds (≥1)
- CNT_W, 8, countdown width; every duration must be < 2^CNT_W

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick_en  in  1  one-clk-wide 1 Hz enable
- car_ew  in  1  EW vehicle sensor, level, synchronous to clk
- ped_req  in  1  pedestrian button pulse/level, synchronous
- night  in  1  night-mode request (used only with NIGHT_FLASH_EN)
- ped_ack  out  1  high while a pedestrian request is pending
- walk  out  1  walk lamp (pedestrians crossing NS road)
- ns_light  out  3  {red,yellow,green} one-hot
- ew_light  out  3  {red,yellow,green} one-hot
- phase  out  3  current state code
- sec_left  out  CNT_W  remaining seconds in current phase

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-phase):
  - state=ALLRED2, sec_left=ALLRED_S
  - ns_light=ew_light=3'b100
  - walk=0, ped_ack=0, pending flag cleared
- All outputs are registered and decoded from state. A lamp change is visible the clk after the transition edge.
- States and codes:
  - NS_GREEN=0: ns=001, ew=100
  - NS_YELLOW=1: ns=010, ew=100
  - ALLRED1=2: both 100
  - EW_GREEN=3: ns=100, ew=001, walk=1
  - EW_YELLOW=4: ns=100, ew=010
  - ALLRED2=5: both 100
  - FLASH=6: optional, see below
- Countdown:
  - On a clk with tick_en=1 and sec_left>1: sec_left decrements.
  - On tick_en=1 with sec_left==1: transition, and sec_left loads the next state's duration.
  - Without tick_en: hold.
- Transitions on expiry:
  - ALLRED2→NS_GREEN
  - NS_GREEN→NS_YELLOW if (car_ew | pending), sampled in the expiry cycle. Otherwise stay NS_GREEN and reload sec_left=1. The rest state is re-evaluated every second.
  - NS_YELLOW→ALLRED1
  - ALLRED1→EW_GREEN
  - EW_GREEN→EW_YELLOW
  - EW_YELLOW→ALLRED2
- Pedestrian handshake:
  - ped_req=1 sets pending; ped_ack = pending.
  - pending clears on the clk that enters EW_GREEN.
  - ped_req in that same clk is absorbed: clear wins, because that request is served by this EW_GREEN.
  - ped_req during EW_GREEN is ignored.
  - ped_req during EW_YELLOW or ALLRED2 sets pending.
- Safety invariant: never green/yellow on both roads. ns_light and ew_light are each always one-hot.
- tick_en asserted on consecutive clks: each pulse counts.
- car_ew dropping mid-EW_GREEN does not shorten the phase.

Optional Feature:
- Macro: NIGHT_FLASH_EN.
- Defined:
  - `night` is sampled at ALLRED2 expiry. If night=1, next state is FLASH instead of NS_GREEN.
  - In FLASH, ns_light toggles between 010 and 000, and ew_light toggles between 100 and 000. Toggling happens on each tick_en; the first FLASH cycle shows lamps on.
  - sec_left holds 0. pending is still latched but not served.
  - On a tick_en with night=0, FLASH→ALLRED2 with sec_left=ALLRED_S.
- Undefined: `night` is ignored, state 6 is unreachable, and behaviour is exactly as above.

Decomposition:
- Package traffic_pkg: state enum/codes, lamp encodings (LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000), CNT_W default.
- One sub-module: phase_timer, a loadable CNT_W down-counter gated by tick_en with an `expire` output (sec_left==1 & tick_en).

Test Plan:
Bench parameters: GREEN_NS_S=4, GREEN_EW_S=3, YELLOW_S=2, ALLRED_S=1, tick_en every 4 clks.
1. Release reset, car_ew=0, ped_req=0 → ALLRED2 for 1 tick, then NS_GREEN indefinitely. sec_left sequence is 4,3,2,1, then 1 reloading each tick. Lamps stay ns=001/ew=100.
2. car_ew=1 from start → full cycle of phases 5,0,1,2,3,4,5 with durations 1,4,2,1,3,2,1 ticks. One-hot and non-conflict assertions are checked every clk.
3. ped_req one-clk pulse during NS_GREEN with car_ew=0 → ped_ack=1 next clk. Reaching NS_GREEN expiry starts the EW cycle. walk=1 for 3 ticks. ped_ack=0 from EW_GREEN entry.
4. ped_req held high through the clk entering EW_GREEN → pending cleared, ped_ack=0. A new ped_req during EW_YELLOW → ped_ack=1.
5. Assert rst mid-EW_GREEN between clk edges → lamps immediately 100/100, state=5, sec_left=1. Normal sequencing resumes after release.
6. (NIGHT_FLASH_EN) night=1 at ALLRED2 expiry → FLASH, with ns toggling 010/000 per tick and ew toggling 100/000. night=0 → ALLRED2, then NS_GREEN. Without the macro, the same stimulus yields NS_GREEN.
